booth_mul_arbiter: RTL
======================

# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one 16x16 Booth multiplier (datapath plus its control path) between N requesters. It grants one request at a time and drives the multiplier's start/data_in loading protocol: multiplicand first, then multiplier. It waits for done, returns the 32-bit signed product to the granted requester over a valid/ready handshake, and converts a hung multiplier into an error response.

## Interface
- N_REQ, 4: number of requesters, 2..8
- WIDTH, 16: operand width; product is 2*WIDTH
- TIMEOUT, 64: maximum WAIT cycles before error response
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  request accepted; one-hot or zero
- req_a  in  N_REQ*WIDTH  signed multiplicands; slice i belongs to requester i
- req_b  in  N_REQ*WIDTH  signed multipliers; slice i belongs to requester i
- rsp_valid  out  N_REQ  response valid; one-hot or zero
- rsp_ready  in  N_REQ  requester accepts response
- rsp_product  out  2*WIDTH  signed product, shared by all requesters
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- mul_start  out  1  to multiplier start
- mul_data  out  WIDTH  to multiplier data_in
- mul_done  in  1  from multiplier done
- mul_product  in  2*WIDTH  from multiplier product
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LDM, HOLD, LDQ, WAIT, RESP.
- IDLE
  - Select requester g: the first set req_valid bit at or after rr_ptr, wrapping around.
  - Drive req_ready[g]=1 combinationally for that cycle only.
  - On that edge, latch a=req_a[g], b=req_b[g] and gid=g, set rr_ptr=(g+1) mod N_REQ, and go to LDM.
  - No request pending: stay in IDLE.
- LDM: mul_start=1, mul_data=a. Go to HOLD.
- HOLD: mul_start=0, mul_data=a. Go to LDQ. This is the second multiplicand cycle the loading protocol needs.
- LDQ: mul_data=b. Clear the timeout counter. Go to WAIT.
- WAIT
  - mul_data holds b.
  - On mul_done=1: latch prod=mul_product, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done: prod=0, err=1, go to RESP.
- RESP
  - rsp_valid[gid]=1; rsp_product=prod; rsp_err=err.
  - Hold all three stable until rsp_ready[gid]=1, then go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Ordering and fairness
  - Exactly one operation is in flight.
  - A requester gets no second grant until every other valid requester has been served once.
- Product arithmetic is the multiplier's: a signed WIDTH x WIDTH result, sign-extended to 2*WIDTH. The arbiter passes it through and never modifies it.
- After a timeout, the next grant's LDM start pulse restarts the multiplier. No separate recovery path exists.

## Timing
- Reset values, asynchronous on rst:
  - state=IDLE, rr_ptr=0, counter=0
  - req_ready=0, rsp_valid=0, rsp_product=0, rsp_err=0
  - mul_start=0, mul_data=0, busy=0
- Reset mid-operation aborts the in-flight request with no response. The requester must resubmit.
- Latency:
  - Grant at cycle 0, mul_start at cycle 1, multiplier operand on mul_data at cycle 3.
  - mul_done is sampled from cycle 4 onward.
  - rsp_valid rises on the cycle after done is sampled.
- mul_done is sampled only in WAIT. It is ignored in every other state, including a stale level left from a previous operation.
- Simultaneous requests: only the round-robin winner sees req_ready. The others must keep req_valid and operands stable.
- A new grant cannot occur in the same cycle as the response handshake. IDLE is always visited for at least one cycle.
- All outputs are registered except req_ready, which is decoded from state, rr_ptr and req_valid.

## Structure
- Shared package holds:
  - the state enumeration
  - localparams for state encoding
  - the counter width, $clog2(TIMEOUT)
- Natural sub-module: rr_arbiter. Inputs are the request vector and rr_ptr; the output is a one-hot grant plus its index. It is combinational and reusable by other shared-resource blocks.

## Test plan
- Single request, requester 0, a=3, b=-4 against the real multiplier -> rsp_valid[0], rsp_product=-12, rsp_err=0, mul_start high for exactly one cycle.
- All four requesters valid from reset, a=i+1, b=10 -> grants in order 0,1,2,3, products 10,20,30,40, one response at a time.
- a=-32768, b=-32768 -> 1073741824. Separately a=32767, b=-1 -> -32767.
- rsp_ready held low for 20 cycles -> rsp_valid, rsp_product and gid stay stable, busy=1, and no new grant occurs although other requests are pending.
- mul_done tied low, TIMEOUT=64 -> rsp_err=1 and rsp_product=0 exactly 64 WAIT cycles after LDQ. The next request then completes correctly.
- rst pulsed during WAIT -> all outputs return to their reset values immediately, and no response is issued. After reset, requester 0 wins over requester 2 when both are valid.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// booth_mul_arbiter_pkg: shared FSM encoding, default parameters and counter-width helper.
package booth_mul_arbiter_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int WIDTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDM  = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_LDQ  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;
    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        LDM  = S_LDM,
        HOLD = S_HOLD,
        LDQ  = S_LDQ,
        WAIT = S_WAIT,
        RESP = S_RESP
    } state_t;
    function automatic int cnt_width(int timeout);
        return $clog2(timeout);
    endfunction
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: request/response and multiplier-control bundle.
// slave modport is the arbiter side, master modport is the requester/multiplier side.
interface booth_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N_REQ*WIDTH-1:0] req_a, req_b;
    logic [2*WIDTH-1:0]     rsp_product, mul_product;
    logic [WIDTH-1:0]       mul_data;
    logic                   rsp_err, mul_start, mul_done, busy;
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
        output req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_data, busy
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
        input  req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_data, busy
    );
endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// booth_mul_arbiter_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Ports: req (request vector), ptr (priority start), gnt (one-hot), gnt_idx (index), gnt_vld (any grant).
module booth_mul_arbiter_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);
    logic [IW-1:0] idx;
    always_comb begin
        idx     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = gnt_vld ? N'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sequencer sharing one Booth multiplier between N_REQ requesters.
// Ports: clk, rst (async, active-high), bus (slave modport: requests, responses, multiplier control).
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               rst,
    booth_mul_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);
    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, gid_q, gid_d, gnt_idx;
    logic [N_REQ-1:0]   gnt, rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, mul_data_q, mul_data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d, mul_start_q, mul_start_d, busy_q, busy_d;
    logic               gnt_vld, take, done_ok, timeout;

    booth_mul_arbiter_rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req(bus.req_valid), .ptr(rr_ptr_q), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
    );

    assign take    = state_q == IDLE && gnt_vld;
    assign done_ok = state_q == WAIT && bus.mul_done;
    assign timeout = state_q == WAIT && !bus.mul_done && cnt_q == CW'(TIMEOUT - 1);
    // Gated by rst so the grant stays low while reset is held even with requests pending.
    assign bus.req_ready   = (take && !rst) ? gnt : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = prod_q;
    assign bus.rsp_err     = err_q;
    assign bus.mul_start   = mul_start_q;
    assign bus.mul_data    = mul_data_q;
    assign bus.busy        = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gid_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            mul_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gid_q       <= gid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            mul_start_q <= mul_start_d;
            mul_data_q  <= mul_data_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = gnt_vld ? LDM : IDLE;
            LDM:     state_d = HOLD;
            HOLD:    state_d = LDQ;
            LDQ:     state_d = WAIT;
            WAIT:    state_d = (done_ok || timeout) ? RESP : WAIT;
            RESP:    state_d = bus.rsp_ready[gid_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        rr_ptr_d    = take ? ((gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
        gid_d       = take ? gnt_idx : gid_q;
        a_d         = take ? bus.req_a[gnt_idx*WIDTH +: WIDTH] : a_q;
        b_d         = take ? bus.req_b[gnt_idx*WIDTH +: WIDTH] : b_q;
        cnt_d       = (state_q == LDQ) ? '0 : (state_q == WAIT && !bus.mul_done) ? cnt_q + 1'b1 : cnt_q;
        prod_d      = done_ok ? bus.mul_product : timeout ? '0 : prod_q;
        err_d       = done_ok ? 1'b0 : timeout ? 1'b1 : err_q;
        mul_start_d = state_d == LDM;
        mul_data_d  = (state_d == LDM || state_d == HOLD) ? a_d : (state_d == LDQ || state_d == WAIT) ? b_q : '0;
        rsp_valid_d = (state_d == RESP) ? N_REQ'(1) << gid_d : '0;
        busy_d      = state_d != IDLE;
    end
endmodule
